// File: rtl/param_fifo.sv
// Single-clock show-ahead FIFO with occupancy counter, watermark flags and synchronous flush.
// Define PARAM_FIFO_ERR_FLAGS_EN to build the sticky overflow/underflow error flags.
module param_fifo #(
    parameter int DATA_WIDTH    = 8,
    parameter int DEPTH         = 16,
    parameter int AFULL_THRESH  = DEPTH - 2,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     wr_en,
    input  logic [DATA_WIDTH-1:0]    din,
    input  logic                     rd_en,
    output logic [DATA_WIDTH-1:0]    dout,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic                     underflow,
    input  logic                     err_clr
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [LW-1:0]         level_q;
    logic                  wr_acc;
    logic                  rd_acc;

    // A write into a full FIFO is only legal when the same edge frees a slot.
    assign wr_acc = wr_en && (!full || rd_en);
    assign rd_acc = rd_en && !empty;

    // NOTE: sequential state is assigned with non-blocking (<=) so every
    // register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
            if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_acc, rd_acc})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    // NOTE: the storage array has no reset; stale words are never visible
    // because dout is masked while empty and pointers restart at zero.
    always_ff @(posedge clk) begin
        if (!flush && wr_acc) mem[wr_ptr] <= din;
    end

    assign level        = level_q;
    assign full         = (level_q == LW'(DEPTH));
    assign empty        = (level_q == '0);
    assign almost_full  = (level_q >= LW'(AFULL_THRESH));
    assign almost_empty = (level_q <= LW'(AEMPTY_THRESH));
    assign dout         = empty ? '0 : mem[rd_ptr];

`ifdef PARAM_FIFO_ERR_FLAGS_EN
    logic overflow_q;
    logic underflow_q;
    logic ovf_set;
    logic unf_set;

    assign ovf_set = wr_en && full && !rd_en && !flush;
    assign unf_set = rd_en && empty && !flush;

    // Set wins over a coincident clear so no error event is lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (ovf_set)      overflow_q <= 1'b1;
            else if (err_clr) overflow_q <= 1'b0;
            if (unf_set)      underflow_q <= 1'b1;
            else if (err_clr) underflow_q <= 1'b0;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`else
    logic unused_err_clr;

    assign unused_err_clr = err_clr;
    assign overflow       = 1'b0;
    assign underflow      = 1'b0;
`endif

endmodule

// File: tb/tb_param_fifo.sv
// Directed plus randomized bench for param_fifo (DEPTH=4, AFULL=3, AEMPTY=1)
// against a queue-based reference model.
module tb_param_fifo;

    localparam int DW     = 8;
    localparam int DEPTH  = 4;
    localparam int AFULL  = 3;
    localparam int AEMPTY = 1;
`ifdef PARAM_FIFO_ERR_FLAGS_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic          flush;
    logic          wr_en;
    logic [DW-1:0] din;
    logic          rd_en;
    logic [DW-1:0] dout;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic [2:0]    level;
    logic          overflow;
    logic          underflow;
    logic          err_clr;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [DW-1:0] q[$];
    bit            m_ovf;
    bit            m_unf;

    param_fifo #(
        .DATA_WIDTH   (DW),
        .DEPTH        (DEPTH),
        .AFULL_THRESH (AFULL),
        .AEMPTY_THRESH(AEMPTY)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .wr_en       (wr_en),
        .din         (din),
        .rd_en       (rd_en),
        .dout        (dout),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .almost_empty(almost_empty),
        .level       (level),
        .overflow    (overflow),
        .underflow   (underflow),
        .err_clr     (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string where);
        logic [DW-1:0] e_dout;
        e_dout = (q.size() == 0) ? '0 : q[0];
        check({where, ".dout"},  32'(dout),  32'(e_dout));
        check({where, ".level"}, 32'(level), 32'(q.size()));
        check({where, ".full"},  32'(full),  32'(q.size() == DEPTH));
        check({where, ".empty"}, 32'(empty), 32'(q.size() == 0));
        check({where, ".afull"}, 32'(almost_full),  32'(q.size() >= AFULL));
        check({where, ".aempty"},32'(almost_empty), 32'(q.size() <= AEMPTY));
        check({where, ".ovf"},   32'(overflow),  32'(ERR_EN && m_ovf));
        check({where, ".unf"},   32'(underflow), 32'(ERR_EN && m_unf));
    endtask

    // Model one clock edge from the FIFO's behavioural rules.
    task automatic model_edge(input bit w, input bit r, input logic [DW-1:0] d,
                              input bit fl, input bit clr);
        int  n;
        bit  ovf_set;
        bit  unf_set;
        n       = q.size();
        ovf_set = w && (n == DEPTH) && !r && !fl;
        unf_set = r && (n == 0) && !fl;
        if (fl) begin
            q.delete();
        end else begin
            if (r && n > 0) void'(q.pop_front());
            if (w && (n < DEPTH || r)) q.push_back(d);
        end
        if (ovf_set)  m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        if (unf_set)  m_unf = 1'b1;
        else if (clr) m_unf = 1'b0;
    endtask

    task automatic step(input bit w, input bit r, input logic [DW-1:0] d,
                        input bit fl, input bit clr, input string where);
        @(negedge clk);
        wr_en   = w;
        rd_en   = r;
        din     = d;
        flush   = fl;
        err_clr = clr;
        model_edge(w, r, d, fl, clr);
        @(posedge clk);
        #1;
        check_all(where);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; din = '0; err_clr = 1'b0;
        m_ovf = 1'b0; m_unf = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        rst = 1'b0;

        // Fill to full, watermarks crossing on the way
        step(1, 0, 8'hA1, 0, 0, "wr1");
        check("wr1.dout_a1", 32'(dout), 32'h00A1);
        step(1, 0, 8'hA2, 0, 0, "wr2");
        check("wr2.aempty_off", 32'(almost_empty), 32'd0);
        step(1, 0, 8'hA3, 0, 0, "wr3");
        check("wr3.afull_on", 32'(almost_full), 32'd1);
        step(1, 0, 8'hA4, 0, 0, "wr4");
        check("wr4.full", 32'(full), 32'd1);

        // Rejected write when full, then drain
        step(1, 0, 8'hB5, 0, 0, "ovf");
        check("ovf.level", 32'(level), 32'd4);
        check("ovf.dout_a1", 32'(dout), 32'h00A1);
        step(0, 1, 8'h00, 0, 0, "rd1");
        check("rd1.dout_a2", 32'(dout), 32'h00A2);
        step(0, 1, 8'h00, 0, 0, "rd2");
        check("rd2.dout_a3", 32'(dout), 32'h00A3);
        step(0, 1, 8'h00, 0, 0, "rd3");
        check("rd3.dout_a4", 32'(dout), 32'h00A4);
        step(0, 1, 8'h00, 0, 0, "rd4");
        check("rd4.dout_zero", 32'(dout), 32'd0);

        // Simultaneous read/write at full, wrapped pointers
        step(0, 0, 8'h00, 0, 1, "clr1");
        for (int i = 1; i <= 4; i++) step(1, 0, DW'(8'hA0 + i), 0, 0, "refill");
        step(1, 1, 8'hC5, 0, 0, "rw_full");
        check("rw_full.level", 32'(level), 32'd4);
        check("rw_full.dout_a2", 32'(dout), 32'h00A2);
        step(0, 1, 8'h00, 0, 0, "rdw1");
        step(0, 1, 8'h00, 0, 0, "rdw2");
        step(0, 1, 8'h00, 0, 0, "rdw3");
        check("rdw3.dout_c5", 32'(dout), 32'h00C5);
        step(0, 1, 8'h00, 0, 0, "rdw4");

        // Simultaneous read/write at empty
        step(1, 1, 8'hD1, 0, 0, "rw_empty");
        check("rw_empty.level", 32'(level), 32'd1);
        check("rw_empty.dout_d1", 32'(dout), 32'h00D1);
        step(0, 0, 8'h00, 0, 1, "err_clr");

        // Flush with concurrent write; a sticky flag must survive it
        step(0, 1, 8'h00, 0, 0, "pop_d1");
        step(0, 1, 8'h00, 0, 0, "unf_again");
        step(1, 0, 8'hE1, 0, 0, "f_wr1");
        step(1, 0, 8'hE2, 0, 0, "f_wr2");
        step(1, 0, 8'hE3, 0, 0, "f_wr3");
        step(1, 0, 8'hE4, 1, 0, "flush");
        check("flush.level", 32'(level), 32'd0);

        // Asynchronous reset between edges at level 2
        step(1, 0, 8'hF1, 0, 0, "r_wr1");
        step(1, 0, 8'hF2, 0, 0, "r_wr2");
        @(negedge clk);
        wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; err_clr = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        q.delete(); m_ovf = 1'b0; m_unf = 1'b0;
        check("arst.empty", 32'(empty), 32'd1);
        check("arst.level", 32'(level), 32'd0);
        check("arst.dout",  32'(dout),  32'd0);
        check_all("arst");
        @(negedge clk);
        rst = 1'b0;

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            bit w, r, fl, clr;
            w   = ($urandom_range(0, 99) < 55);
            r   = ($urandom_range(0, 99) < 45);
            fl  = ($urandom_range(0, 99) < 3);
            clr = ($urandom_range(0, 99) < 5);
            step(w, r, DW'($urandom), fl, clr, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/param_fifo.md
Name: param_fifo

Overview:
- Synchronous single-clock FIFO, next generation of the SPI-path buffer, with parametrised width, depth and watermarks.
- Adds an occupancy output, almost-full/almost-empty flags, synchronous flush, and defined simultaneous read/write behaviour at full.
- Optional sticky overflow/underflow error flags.
- Sits between the SPI shift engines and the register/bus side, one instance per direction (TX and RX).

Parameters:
DATA_WIDTH, 8, word width in bits (>=1)
DEPTH, 16, number of entries; power of two, >=2
AFULL_THRESH, DEPTH-2, almost_full asserts when level >= this value (1..DEPTH)
AEMPTY_THRESH, 2, almost_empty asserts when level <= this value (0..DEPTH-1)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  reset, asynchronous, active-high
flush  input  1  synchronous clear of contents
wr_en  input  1  write request
din  input  DATA_WIDTH  write data
rd_en  input  1  read/pop request
dout  output  DATA_WIDTH  head-of-queue word (show-ahead)
full  output  1  level == DEPTH
empty  output  1  level == 0
almost_full  output  1  level >= AFULL_THRESH
almost_empty  output  1  level <= AEMPTY_THRESH
level  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
overflow  output  1  sticky: write rejected (optional feature)
underflow  output  1  sticky: read on empty (optional feature)
err_clr  input  1  clears overflow/underflow (optional feature)

Behaviour:
- Reset (rst=1, async): wr_ptr=0, rd_ptr=0, level=0, overflow=0, underflow=0.
  - Resulting outputs: empty=1, full=0, almost_empty=1, almost_full=0 (AFULL_THRESH>=1), dout=0.
  - Memory contents are not reset.
  - Reset mid-operation discards all data immediately.
- Pointers are $clog2(DEPTH) bits and wrap naturally modulo DEPTH. level is a separate registered counter.
- Accept rules, evaluated on a rising edge:
  - wr_acc = wr_en && (!full || rd_en)
  - rd_acc = rd_en && !empty
- Write accepted: mem[wr_ptr] <= din; wr_ptr+1.
- Read accepted: rd_ptr+1.
- level update:
  - level + wr_acc - rd_acc, never outside 0..DEPTH.
  - Simultaneous write and read when full: both accepted, level stays DEPTH, the written word lands in the slot being freed.
  - Simultaneous write and read when empty: write accepted, read rejected, level becomes 1.
- dout:
  - Combinational from mem[rd_ptr] when !empty; forced to 0 when empty.
  - A word written to an empty FIFO appears on dout the cycle after the write edge (one-cycle write-to-read latency).
  - A pop advances dout the cycle after the edge.
- Flags are combinational decodes of the level register and change only on clock edges.
- flush:
  - Synchronous; has priority over wr_en/rd_en in the same cycle (neither is accepted).
  - Sets pointers=0 and level=0.
  - Does not clear overflow/underflow.
- No FSM beyond the counter/pointer state. Events outside the accept rules (write when full without read, read when empty) are ignored with no state change, apart from the error flags.

Optional Feature:
- Macro PARAM_FIFO_ERR_FLAGS_EN.
- When defined:
  - overflow sets on any edge with wr_en && full && !rd_en && !flush.
  - underflow sets on any edge with rd_en && empty && !flush. This includes a simultaneous write to an empty FIFO.
  - Both flags hold until err_clr=1 on an edge or rst. If set and clear conditions coincide, set wins.
- When not defined:
  - overflow and underflow are tied to 0.
  - err_clr is ignored.
  - No flag registers are synthesised.

Test Plan:
- DEPTH=4, AFULL=3, AEMPTY=1. Reset, then write A1,A2,A3,A4 on consecutive cycles:
  - level 1,2,3,4.
  - almost_empty deasserts when level=2.
  - almost_full asserts at level=3.
  - full=1 after 4th edge.
  - dout=A1 from the cycle after the first write.
- Full FIFO. 5th write B5 with rd_en=0: rejected, level=4, overflow=1 (macro on). Then read 4 times: dout sequence A1,A2,A3,A4, then empty=1 and dout=0.
- Full FIFO [A1..A4]. wr_en=rd_en=1 with din=C5: level stays 4, dout=A2 next cycle. Subsequent reads give A2,A3,A4,C5 (pointer wrap verified).
- Empty FIFO. wr_en=rd_en=1 with din=D1: level=1, dout=D1, underflow=1 (macro on). err_clr pulse then gives underflow=0.
- Level=3. flush=1 together with wr_en=1: next cycle level=0, empty=1, write discarded, error flags unchanged.
- Level=2. Assert rst asynchronously between edges: empty=1, level=0, dout=0 immediately, without waiting for a clock edge.
